axis_sample_tx: RTL and testbench

- AXI-Stream transmitter that buffers 16-bit samples from a parallel producer and drives the rx side of the lpffir_axis filter.
- Framing: asserts tlast every FRAME_LEN beats.
- Control: start/stop state machine; on stop, completes the open frame, zero-padding it if the buffer runs dry.
- Sits between the sample source (ADC capture / test host) and the filter.

---
 rtl/axis_sample_tx.sv | 160 ++++++++++++++++
 tb/tb_axis_sample_tx.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_sample_tx.sv
`default_nettype none
// ============================================================================
// axis_sample_tx : FIFO-buffered 16-bit sample source for an AXI-Stream rx port,
//                  framed with tlast; frame counter behind AXIS_SAMPLE_TX_FRAME_CNT_EN.
// Revision       : 1.0
// ============================================================================

module axis_sample_tx #(
    parameter int DEPTH     = 8,
    parameter int FRAME_LEN = 16
) (
    input  logic        aclk_i,
    input  logic        aresetn_i,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [15:0] in_data_i,
    output logic        tx_tvalid_o,
    input  logic        tx_tready_i,
    output logic [15:0] tx_tdata_o,
    output logic        tx_tlast_o,
    output logic        busy_o
`ifdef AXIS_SAMPLE_TX_FRAME_CNT_EN
    ,
    output logic [15:0] frames_o
`endif
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [15:0] LAST_BEAT = 16'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [15:0] beat_cnt_q, beat_cnt_d;
    logic [15:0] mem_q [DEPTH];

    logic        w_empty;
    logic        w_full;
    logic        w_at_last;
    logic        w_cnt_nz;
    logic        w_push;
    logic        w_beat;
    logic        w_pop;
    logic [15:0] w_head;

    // Extra wrap bit on each pointer distinguishes full from empty.
    assign w_empty   = (wr_ptr_q == rd_ptr_q);
    assign w_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign w_at_last = (beat_cnt_q == LAST_BEAT);
    assign w_cnt_nz  = (beat_cnt_q != 16'd0);
    assign w_head    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        tx_tvalid_o = 1'b0;
        in_ready_o  = 1'b0;
        case (state_q)
            S_STREAM: begin
                tx_tvalid_o = !w_empty;
                in_ready_o  = !w_full;
            end
            S_FLUSH:  tx_tvalid_o = w_cnt_nz;
            default:  tx_tvalid_o = 1'b0;
        endcase
    end

    // A flush beat with a drained FIFO carries zero padding.
    assign tx_tdata_o = (tx_tvalid_o && !w_empty) ? w_head : 16'h0000;
    assign tx_tlast_o = tx_tvalid_o && w_at_last;
    assign busy_o     = (state_q != S_IDLE);

    assign w_push = in_valid_i && in_ready_o;
    assign w_beat = tx_tvalid_o && tx_tready_i;
    assign w_pop  = w_beat && !w_empty;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        beat_cnt_d = beat_cnt_q;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (w_beat) begin
            beat_cnt_d = w_at_last ? 16'd0 : beat_cnt_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (stop_i) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // Leftover samples beyond the closing frame are dropped here.
                if (!w_cnt_nz || (w_beat && w_at_last)) begin
                    state_d  = S_IDLE;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_ff @(posedge aclk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_data_i;
        end
    end

`ifdef AXIS_SAMPLE_TX_FRAME_CNT_EN
    logic [15:0] frames_q;

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            frames_q <= '0;
        end else if (w_beat && tx_tlast_o) begin
            frames_q <= frames_q + 16'd1;
        end
    end

    assign frames_o = frames_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axis_sample_tx.sv
`default_nettype none
// ============================================================================
// tb_axis_sample_tx : directed and random stimulus for axis_sample_tx, checked
//                     cycle by cycle against a queue-based model of the stream.
// Revision          : 1.0
// ============================================================================

module tb_axis_sample_tx;

    localparam int DEPTH     = 8;
    localparam int FRAME_LEN = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'h0;
    logic        tready = 1'b0;
    logic        in_ready_o;
    logic        tx_tvalid_o;
    logic [15:0] tx_tdata_o;
    logic        tx_tlast_o;
    logic        busy_o;
    logic [15:0] dut_frames;

    always #5 clk = ~clk;

`ifdef AXIS_SAMPLE_TX_FRAME_CNT_EN
    logic [15:0] frames_o;
    assign dut_frames = frames_o;
`else
    assign dut_frames = 16'h0;
`endif

    axis_sample_tx #(.DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN)) dut (
        .aclk_i      (clk),
        .aresetn_i   (rst_n),
        .start_i     (start),
        .stop_i      (stop),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data),
        .tx_tvalid_o (tx_tvalid_o),
        .tx_tready_i (tready),
        .tx_tdata_o  (tx_tdata_o),
        .tx_tlast_o  (tx_tlast_o),
        .busy_o      (busy_o)
`ifdef AXIS_SAMPLE_TX_FRAME_CNT_EN
        ,
        .frames_o    (frames_o)
`endif
    );

    // Model: sample queue, position within the frame, mode 0=idle 1=stream 2=flush.
    int          q[$];
    int          pos;
    int          mode;
    int          frames_m;
    logic        e_ready, e_valid, e_last, e_busy;
    logic [15:0] e_data;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;

    function automatic logic [35:0] obs();
        return {in_ready_o, tx_tvalid_o, tx_tlast_o, busy_o, tx_tdata_o, dut_frames};
    endfunction

    function automatic logic [35:0] expv();
        logic [15:0] ef;
`ifdef AXIS_SAMPLE_TX_FRAME_CNT_EN
        ef = 16'(frames_m);
`else
        ef = 16'h0;
`endif
        return {e_ready, e_valid, e_last, e_busy, e_data, ef};
    endfunction

    function automatic void model_reset();
        q.delete();
        pos      = 0;
        mode     = 0;
        frames_m = 0;
    endfunction

    function automatic void model_eval();
        e_busy  = (mode != 0);
        e_ready = (mode == 1) && (q.size() < DEPTH);
        if (mode == 1)      e_valid = (q.size() > 0);
        else if (mode == 2) e_valid = (pos != 0);
        else                e_valid = 1'b0;
        e_data  = (e_valid && q.size() > 0) ? 16'(q[0]) : 16'h0;
        e_last  = e_valid && (pos == FRAME_LEN - 1);
    endfunction

    // Advance model and DUT by one clock using the inputs currently driven.
    task automatic tick();
        bit push, beat;
        int old_pos;
        model_eval();
        push    = in_valid && e_ready;
        beat    = e_valid && tready;
        old_pos = pos;
        if (beat) begin
            if (q.size() > 0) void'(q.pop_front());
            if (e_last) frames_m++;
            pos = (pos + 1) % FRAME_LEN;
        end
        if (push) q.push_back(int'(in_data));
        case (mode)
            0: if (start) mode = 1;
            1: if (stop) mode = 2;
            default: if (old_pos == 0 || (beat && e_last)) begin
                mode = 0;
                q.delete();
            end
        endcase
        @(posedge clk);
        @(negedge clk);
        cyc++;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== 36'h0) begin
            n_bad++;
            $display("FAIL reset_async observed=%h expected=%h", obs(), 36'h0);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (obs() !== 36'h0) begin
            n_bad++;
            $display("FAIL reset_held observed=%h expected=%h", obs(), 36'h0);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int k = 0;
        int tl = 0;
        start  = 1'b1;
        tready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            in_valid = (k < 8);
            in_data  = 16'(k + 1);
            model_eval();
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL basic cyc=%0d observed=%h expected=%h", cyc, obs(), expv());
            end
            if (tx_tvalid_o && tready && tx_tlast_o) begin
                tl++;
                n_cmp++;
                if (tx_tdata_o !== 16'(4 * tl)) begin
                    n_bad++;
                    $display("FAIL basic_tlast_value observed=%0d expected=%0d", tx_tdata_o, 4 * tl);
                end
            end
            if (in_valid && in_ready_o) k++;
            tick();
        end
        in_valid = 1'b0;
        stop     = 1'b1;
        for (int c = 0; c < 20 && !(c > 0 && !busy_o); c++) begin
            model_eval();
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL basic_stop cyc=%0d observed=%h expected=%h", cyc, obs(), expv());
            end
            tick();
        end
        n_cmp++;
        if (busy_o !== 1'b0 || tl != 2) begin
            n_bad++;
            $display("FAIL basic_end observed busy=%b tlasts=%0d expected busy=0 tlasts=2", busy_o, tl);
        end
    endtask

    task automatic test_full_stall();
        start  = 1'b1;
        tready = 1'b0;
        for (int c = 0; c < 44; c++) begin
            if (c == 10) tready = 1'b1;
            in_valid = (c < 34);
            in_data  = 16'($urandom);
            model_eval();
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL full_stall cyc=%0d observed=%h expected=%h", cyc, obs(), expv());
            end
            if (c == 9) begin
                n_cmp++;
                if (in_ready_o !== 1'b0) begin
                    n_bad++;
                    $display("FAIL full_stall_ready observed=%b expected=0", in_ready_o);
                end
            end
            tick();
        end
        in_valid = 1'b0;
        stop     = 1'b1;
        for (int c = 0; c < 20 && !(c > 0 && !busy_o); c++) begin
            model_eval();
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL full_stall_stop cyc=%0d observed=%h expected=%h", cyc, obs(), expv());
            end
            tick();
        end
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL full_stall_idle observed busy=%b expected 0", busy_o);
        end
    endtask

    task automatic test_pad_flush();
        int k = 0;
        int pads = 0;
        start  = 1'b1;
        tready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_valid = (k < 2);
            in_data  = (k == 0) ? 16'd5 : 16'd6;
            model_eval();
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL pad_fill cyc=%0d observed=%h expected=%h", cyc, obs(), expv());
            end
            if (in_valid && in_ready_o) k++;
            tick();
        end
        in_valid = 1'b0;
        stop     = 1'b1;
        for (int c = 0; c < 10 && !(c > 0 && !busy_o); c++) begin
            model_eval();
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL pad_flush cyc=%0d observed=%h expected=%h", cyc, obs(), expv());
            end
            if (tx_tvalid_o && tready && tx_tdata_o == 16'h0) pads++;
            tick();
        end
        n_cmp++;
        if (pads != 2 || busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL pad_count observed pads=%0d busy=%b expected pads=2 busy=0", pads, busy_o);
        end
    endtask

    task automatic test_discard();
        start  = 1'b1;
        tready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = (c >= 1);
            in_data  = 16'($urandom);
            model_eval();
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL discard_fill cyc=%0d observed=%h expected=%h", cyc, obs(), expv());
            end
            tick();
        end
        in_valid = 1'b0;
        stop     = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c == 2) start = 1'b1;
            model_eval();
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL discard cyc=%0d observed=%h expected=%h", cyc, obs(), expv());
            end
            if (c >= 1) begin
                n_cmp++;
                if (tx_tvalid_o !== 1'b0) begin
                    n_bad++;
                    $display("FAIL discard_tvalid c=%0d observed=%b expected=0", c, tx_tvalid_o);
                end
            end
            tick();
        end
        stop = 1'b1;
        for (int c = 0; c < 10 && !(c > 0 && !busy_o); c++) begin
            model_eval();
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL discard_stop cyc=%0d observed=%h expected=%h", cyc, obs(), expv());
            end
            tick();
        end
    endtask

    task automatic test_stability();
        logic [15:0] hold_d;
        logic        hold_l;
        start  = 1'b1;
        tready = 1'b1;
        for (int c = 0; c < 11; c++) begin
            if (c == 6) tready = 1'b0;
            in_valid = (c == 1 || c == 2 || (c >= 6 && c <= 8));
            in_data  = 16'($urandom);
            model_eval();
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL stab_fill cyc=%0d observed=%h expected=%h", cyc, obs(), expv());
            end
            tick();
        end
        hold_d = tx_tdata_o;
        hold_l = tx_tlast_o;
        for (int c = 0; c < 6; c++) begin
            stop     = (c == 2);
            in_valid = c[0];
            in_data  = 16'($urandom);
            model_eval();
            n_cmp++;
            if (obs() !== expv() || {tx_tvalid_o, tx_tdata_o, tx_tlast_o} !== {1'b1, hold_d, hold_l}) begin
                n_bad++;
                $display("FAIL stability cyc=%0d observed=%h expected=%h held=%h", cyc, obs(), expv(), hold_d);
            end
            tick();
        end
        in_valid = 1'b0;
        tready   = 1'b1;
        for (int c = 0; c < 10 && !(c > 0 && !busy_o); c++) begin
            model_eval();
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL stab_drain cyc=%0d observed=%h expected=%h", cyc, obs(), expv());
            end
            tick();
        end
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL stab_idle observed busy=%b expected 0", busy_o);
        end
    endtask

    task automatic test_reset_mid();
        int beats = 0;
        int first_last = 0;
        start  = 1'b1;
        tready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_valid = (c >= 1 && c <= 4);
            if (c == 4) tready = 1'b0;
            in_data  = 16'($urandom);
            model_eval();
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL rmid_fill cyc=%0d observed=%h expected=%h", cyc, obs(), expv());
            end
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== 36'h0) begin
            n_bad++;
            $display("FAIL reset_mid observed=%h expected=%h", obs(), 36'h0);
        end
        model_reset();
        in_valid = 1'b0;
        tready   = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c >= 1 && c <= 6);
            in_data  = 16'($urandom);
            model_eval();
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL rmid_restart cyc=%0d observed=%h expected=%h", cyc, obs(), expv());
            end
            if (tx_tvalid_o && tready) begin
                beats++;
                if (tx_tlast_o && first_last == 0) first_last = beats;
            end
            tick();
        end
        n_cmp++;
        if (first_last != 4) begin
            n_bad++;
            $display("FAIL rmid_first_tlast observed=%0d expected=4", first_last);
        end
        in_valid = 1'b0;
        stop     = 1'b1;
        for (int c = 0; c < 10 && !(c > 0 && !busy_o); c++) begin
            model_eval();
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL rmid_stop cyc=%0d observed=%h expected=%h", cyc, obs(), expv());
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 16'($urandom);
            tready   = ($urandom_range(0, 2) != 0);
            start    = ($urandom_range(0, 15) == 0);
            stop     = ($urandom_range(0, 39) == 0);
            model_eval();
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL random cyc=%0d observed=%h expected=%h", cyc, obs(), expv());
            end
            tick();
        end
        in_valid = 1'b0;
        tready   = 1'b1;
        stop     = 1'b1;
        for (int c = 0; c < 30 && !(c > 0 && !busy_o); c++) begin
            model_eval();
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL random_stop cyc=%0d observed=%h expected=%h", cyc, obs(), expv());
            end
            tick();
        end
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL random_idle observed busy=%b expected 0", busy_o);
        end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_basic();
        test_full_stall();
        test_pad_flush();
        test_discard();
        test_stability();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
